// File: rtl/uart_cmd_scheduler_pkg.sv
// Shared types and command bytes for the UART command scheduler.
package uart_cmd_scheduler_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP} state_t;

    // Winning event class presented by the tracker to the FSM.
    typedef enum logic [2:0] {EV_NONE, EV_MAC, EV_CHG, EV_STOP, EV_REP, EV_HB} ev_sel_t;

    localparam logic [7:0] CMD_STOP   = 8'hFF;
    localparam logic [7:0] CMD_WAVE   = 8'h1A;
    localparam logic [7:0] CMD_CIRCLE = 8'h19;
    localparam logic [7:0] CMD_PUIPUI = 8'h10;

    // Drive directions are a bitmask; diagonals OR two of these together.
    localparam logic [7:0] DIR_UP    = 8'h01;
    localparam logic [7:0] DIR_DOWN  = 8'h02;
    localparam logic [7:0] DIR_LEFT  = 8'h04;
    localparam logic [7:0] DIR_RIGHT = 8'h08;

endpackage

// File: rtl/uart_cmd_scheduler_if.sv
// Command-source / transmitter bundle of the UART command scheduler.
interface uart_cmd_scheduler_if;
    logic       drv_valid;
    logic [7:0] drv_cmd;
    logic       mac_req;
    logic [7:0] mac_cmd;
    logic       mac_ack;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       sched_busy;
    logic       mac_ovf;
    logic       tx_err;

    modport master (output drv_valid, drv_cmd, mac_req, mac_cmd, tx_busy,
                    input  mac_ack, tx_start, tx_data, sched_busy, mac_ovf, tx_err);
    modport slave  (input  drv_valid, drv_cmd, mac_req, mac_cmd, tx_busy,
                    output mac_ack, tx_start, tx_data, sched_busy, mac_ovf, tx_err);
endinterface

// File: rtl/uart_cmd_event_tracker.sv
// Drive/macro event bookkeeping and priority selection for the scheduler.
// CMD_HEARTBEAT_EN adds an idle heartbeat (8'hFF) as the lowest-priority event.
module uart_cmd_event_tracker
    import uart_cmd_scheduler_pkg::*;
#(
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       drv_valid,
    input  logic [7:0] drv_cmd,
    input  logic       mac_req,
    input  logic [7:0] mac_cmd,
`ifdef CMD_HEARTBEAT_EN
    input  logic       idle,
`endif
    input  logic       take,
    output ev_sel_t    ev_sel,
    output logic [7:0] ev_byte,
    output logic       mac_pend,
    output logic       mac_ack,
    output logic       mac_ovf
);
    localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYCLES);

    logic             drv_prev, stop_pend;
    logic [7:0]       last_drv, mac_hold;
    logic [CNT_W-1:0] rep_cnt;
    logic             chg, rel, rep_due, hb_due;

    assign chg     = drv_valid && (!drv_prev || drv_cmd != last_drv);
    assign rel     = !drv_valid && drv_prev;
    assign rep_due = drv_valid && !chg && rep_cnt == REP_MAX;

`ifdef CMD_HEARTBEAT_EN
    localparam int HB_W = CNT_W + 2;
    localparam logic [HB_W-1:0] HB_MAX = HB_W'(REPEAT_CYCLES * 4);
    logic [HB_W-1:0] hb_cnt;
    assign hb_due = hb_cnt == HB_MAX;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hb_cnt <= '0;
        else if (take || drv_valid || mac_pend || stop_pend || rel || rep_due || !idle)
            hb_cnt <= '0;
        else if (!hb_due)
            hb_cnt <= hb_cnt + HB_W'(1);
    end
`else
    assign hb_due = 1'b0;
`endif

    always_comb begin
        ev_sel  = EV_NONE;
        ev_byte = CMD_STOP;
        if (mac_pend) begin
            ev_sel  = EV_MAC;
            ev_byte = mac_hold;
        end else if (chg) begin
            ev_sel  = EV_CHG;
            ev_byte = drv_cmd;
        end else if (stop_pend || rel) begin
            ev_sel  = EV_STOP;
        end else if (rep_due) begin
            ev_sel  = EV_REP;
            ev_byte = last_drv;
        end else if (hb_due) begin
            ev_sel  = EV_HB;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drv_prev  <= 1'b0;
            last_drv  <= CMD_STOP;
            stop_pend <= 1'b0;
            rep_cnt   <= '0;
            mac_hold  <= CMD_STOP;
            mac_pend  <= 1'b0;
            mac_ack   <= 1'b0;
            mac_ovf   <= 1'b0;
        end else begin
            drv_prev <= drv_valid;
            mac_ack  <= mac_req && !mac_pend;
            if (take && ev_sel == EV_MAC) mac_pend <= 1'b0;
            if (mac_req) begin
                if (mac_pend) mac_ovf <= 1'b1;
                else begin
                    mac_hold <= mac_cmd;
                    mac_pend <= 1'b1;
                end
            end
            // A release that is taken the same cycle never needs latching.
            if (take && ev_sel == EV_STOP)   stop_pend <= 1'b0;
            else if (rel)                    stop_pend <= 1'b1;
            else if (drv_valid && !drv_prev) stop_pend <= 1'b0;
            if (take && ev_sel == EV_CHG)  last_drv <= drv_cmd;
            if (take && ev_sel == EV_STOP) last_drv <= CMD_STOP;
            if (take && (ev_sel == EV_CHG || ev_sel == EV_STOP || ev_sel == EV_REP))
                rep_cnt <= '0;
            else if (rep_cnt != REP_MAX)
                rep_cnt <= rep_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_cmd_scheduler.sv
// Arbitrates drive and macro commands onto one UART transmitter with gap/ack control.
// Build option CMD_HEARTBEAT_EN enables the idle heartbeat in the event tracker.
module uart_cmd_scheduler
    import uart_cmd_scheduler_pkg::*;
#(
    parameter int GAP_CYCLES    = 20840,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int ACK_TIMEOUT   = 1024,
    parameter int CNT_W         = 23
) (
    input  logic                clk,
    input  logic                reset,
    uart_cmd_scheduler_if.slave bus
);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             tx_start_r, tx_err_r;
    logic [7:0]       tx_data_r, ev_byte;
    ev_sel_t          ev_sel;
    logic             mac_pend, take;

    // Never launch into a transmitter that still reports busy.
    assign take = (state == IDLE) && (ev_sel != EV_NONE) && !bus.tx_busy;

    uart_cmd_event_tracker #(.REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W)) u_trk (
        .clk(clk), .reset(reset),
        .drv_valid(bus.drv_valid), .drv_cmd(bus.drv_cmd),
        .mac_req(bus.mac_req), .mac_cmd(bus.mac_cmd),
`ifdef CMD_HEARTBEAT_EN
        .idle(state == IDLE),
`endif
        .take(take), .ev_sel(ev_sel), .ev_byte(ev_byte),
        .mac_pend(mac_pend), .mac_ack(bus.mac_ack), .mac_ovf(bus.mac_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            tx_start_r <= 1'b0;
            tx_data_r  <= CMD_STOP;
            tx_err_r   <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    tx_data_r  <= ev_byte;
                    tx_start_r <= 1'b1;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.tx_busy) state <= WAIT_DONE;
                    else if (cnt == ACK_LAST) begin
                        tx_err_r <= 1'b1;
                        cnt      <= '0;
                        state    <= GAP;
                    end else cnt <= cnt + CNT_W'(1);
                end
                WAIT_DONE: if (!bus.tx_busy) begin
                    cnt   <= '0;
                    state <= GAP;
                end
                GAP: begin
                    if (cnt == GAP_LAST) state <= IDLE;
                    else cnt <= cnt + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_start   = tx_start_r;
    assign bus.tx_data    = tx_data_r;
    assign bus.tx_err     = tx_err_r;
    assign bus.sched_busy = (state != IDLE) || mac_pend;
endmodule

// File: doc/uart_cmd_scheduler.md
Name: uart_cmd_scheduler

Overview:
- Sequences the shared UART transmit path between two command sources: the held-key drive channel (direction codes) and the one-shot macro channel (wave 8'h1A, circle 8'h19, puipui 8'h10).
- Sits between the keyboard/instruction-encoder logic and the byte transmitter.
- Decides which byte goes out, and when; issues start pulses; enforces an inter-frame gap, periodic resend and a single STOP (8'hFF) on key release.

Parameters:
- GAP_CYCLES, 20840, idle clk cycles between end of one frame and the next start (two bit times at 9600 baud, 100 MHz).
- REPEAT_CYCLES, 5000000, resend period for an unchanged held drive command (50 ms).
- ACK_TIMEOUT, 1024, clk cycles allowed for tx_busy to rise after tx_start.
- CNT_W, 23, width of the shared gap/repeat/timeout counter; must hold max(GAP_CYCLES, REPEAT_CYCLES, ACK_TIMEOUT).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- drv_valid  in  1  drive key held (level).
- drv_cmd  in  8  drive command byte; meaningful while drv_valid=1.
- mac_req  in  1  one-cycle request pulse for a macro command.
- mac_cmd  in  8  macro byte; sampled with mac_req.
- mac_ack  out  1  one-cycle pulse: macro captured into the holding register.
- tx_start  out  1  one-cycle pulse to the transmitter.
- tx_data  out  8  byte to send; stable from the tx_start cycle until tx_busy falls.
- tx_busy  in  1  transmitter frame in progress.
- sched_busy  out  1  state != IDLE or a macro is pending.
- mac_ovf  out  1  sticky: mac_req arrived while the holding register was full.
- tx_err  out  1  sticky: ACK_TIMEOUT expired.

Behaviour:
- Reset (async, reset=0):
  - State=IDLE, counter=0, mac_pend=0, last_drv=8'hFF, drv_prev=0, rep_due=0.
  - Outputs: tx_start=0, tx_data=8'hFF, mac_ack=0, mac_ovf=0, tx_err=0.
  - Reset mid-frame abandons the frame; no STOP is sent.
- Macro capture (any state):
  - mac_req with mac_pend=0: latch mac_cmd, set mac_pend, pulse mac_ack on the next cycle.
  - mac_req with mac_pend=1: discard mac_req, set mac_ovf.
- Drive events are evaluated every cycle and prioritised in this order:
  1. pending macro;
  2. drive change — drv_valid=1 and (drv_prev=0 or drv_cmd!=last_drv);
  3. release — drv_valid=0 and drv_prev=1, which queues STOP 8'hFF;
  4. rep_due — drv_valid=1, cmd unchanged, repeat counter reached REPEAT_CYCLES.
- Drive event latching:
  - Release is latched as stop_pend, so it is not lost while the scheduler is busy.
  - A press/change seen while busy is re-evaluated in IDLE against last_drv.
  - A release followed by a re-press before issue clears stop_pend; the re-press wins.
- Repeat counter:
  - Separate REPEAT counter, reset whenever a drive byte is issued.
  - Saturates at REPEAT_CYCLES.
- States:
  - IDLE: if any event is pending, load tx_data with the winner and go to ISSUE. Load last_drv on drive/STOP issues and clear the consumed flag.
  - ISSUE: tx_start=1 for exactly one cycle; clear counter; go to WAIT_ACK.
  - WAIT_ACK: tx_busy=1 moves to WAIT_DONE. If counter reaches ACK_TIMEOUT-1, set tx_err, drop the byte and go to GAP.
  - WAIT_DONE: stay while tx_busy=1; on tx_busy=0 clear counter and go to GAP.
  - GAP: count to GAP_CYCLES-1, then go to IDLE.
- Latency: event in IDLE to tx_start is 2 cycles. Back-to-back frames are separated by ≥ GAP_CYCLES idle cycles.
- Issue rule: tx_start never asserts outside ISSUE, and never while tx_busy=1.
- Macro consumption: a macro clears mac_pend on issue. An issued byte is not retried after timeout.
- Counter: unsigned CNT_W wrap-free; compares use ==.

Optional Feature:
- CMD_HEARTBEAT_EN defined:
  - In IDLE with drv_valid=0 and nothing pending for REPEAT_CYCLES×4 cycles, the scheduler issues 8'hFF as the lowest-priority event.
  - The heartbeat timer restarts on any issue.
- Not defined: no byte is ever sent without a macro or drive event.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP);
  - CMD_STOP=8'hFF, CMD_WAVE=8'h1A, CMD_CIRCLE=8'h19, CMD_PUIPUI=8'h10;
  - the direction code constants.
- One natural sub-module, uart_cmd_event_tracker: it owns drv_prev, last_drv, stop_pend, the repeat counter and the macro holding register, and presents prioritised event/byte outputs to the FSM.

Test Plan:
- Hold drv_cmd=8'h08 for 12 ms with a behavioural tx (busy 1040 cycles) → exactly one 8'h08 frame; then release → exactly one 8'hFF frame, ≥20840 cycles after the first frame ends.
- Hold 8'h08 for 120 ms → frames at 0 ms, ~50 ms and ~100 ms, all 8'h08.
- Two mac_req pulses (8'h1A, then 8'h19 one cycle later) with drv_valid=1 8'h01 → 8'h1A sent first, one mac_ack, mac_ovf=1, then 8'h01.
- Change drv_cmd 8'h08→8'h0A during WAIT_DONE → next frame after the gap is 8'h0A; no 8'hFF in between.
- Model tx_busy stuck 0 → tx_err=1 after 1024 cycles; FSM returns to IDLE after the gap; no second tx_start without an event.
- Assert reset=0 mid-WAIT_DONE → tx_start=0, tx_data=8'hFF, flags cleared; no frame issued until a new event after reset=1.
